// File: rtl/led_matrix_column_scanner.sv
// Column-multiplexed LED matrix driver: blank gap, column dwell, one image snapshot per frame.
// Optional low-level blink is enabled with `define LED_MATRIX_LOW_LEVEL_BLINK_EN.
module led_matrix_column_scanner #(
    parameter int unsigned COLUMNS      = 5,
    parameter int unsigned ROWS         = 7,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    scan_enable,
    input  logic [COLUMNS*ROWS-1:0] column_images,
    input  logic [1:0]              tank_level_status,
    output logic [COLUMNS-1:0]      columns_n,
    output logic [ROWS-1:0]         rows,
    output logic                    frame_tick
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

    typedef enum logic [1:0] {StOff, StBlank, StDrive} state_e;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [COLUMNS*ROWS-1:0] snapshot_q, snapshot_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    load_snap;
    logic                    row_gate;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StOff;
            col_q        <= '0;
            cnt_q        <= '0;
            snapshot_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            snapshot_q   <= snapshot_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        frame_tick_d = 1'b0;
        load_snap    = 1'b0;
        if (!scan_enable) begin
            state_d = StOff;
            col_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d   = StBlank;
                    col_d     = '0;
                    cnt_d     = '0;
                    load_snap = 1'b1;
                end
                StBlank: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDrive: begin
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        if (col_q == COL_W'(COLUMNS - 1)) begin
                            col_d        = '0;
                            load_snap    = 1'b1;
                            frame_tick_d = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StOff;
            endcase
        end
        snapshot_d = load_snap ? column_images : snapshot_q;
    end

`ifdef LED_MATRIX_LOW_LEVEL_BLINK_EN
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [1:0]      snap_level_q;
    logic [FC_W-1:0] frame_cnt_q;
    logic            blink_phase_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            snap_level_q  <= 2'b00;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            if (load_snap) begin
                snap_level_q <= tank_level_status;
            end
            if (state_q == StOff || snap_level_q != 2'b00) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= 1'b1;
            end else if (frame_tick_q) begin
                if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FC_W'(1);
                end
            end
        end
    end

    assign row_gate = blink_phase_q;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = BLINK_FRAMES ^ {30'b0, tank_level_status};
    assign row_gate   = 1'b1;
`endif

    // Decoded only from registered state, so inputs never reach the pins combinationally.
    always_comb begin
        columns_n = '1;
        rows      = '0;
        if (state_q == StDrive) begin
            for (int c = 0; c < int'(COLUMNS); c++) begin
                if (col_q == COL_W'(c)) columns_n[c] = 1'b0;
            end
            rows = row_gate ? snapshot_q[col_q*ROWS +: ROWS] : '0;
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Self-checking bench for led_matrix_column_scanner: vector table, directed corners, random vs model.
// Blink expectations follow LED_MATRIX_LOW_LEVEL_BLINK_EN when it is defined.
module tb_led_matrix_column_scanner;

    localparam int C = 5, R = 7, DW = 4, BL = 2, BF = 2;
    localparam int SLOT = BL + DW, FRAME = C * SLOT;

    logic             clock = 1'b0;
    logic             reset, scan_enable;
    logic [C*R-1:0]   column_images;
    logic [1:0]       tank_level_status;
    logic [C-1:0]     columns_n;
    logic [R-1:0]     rows;
    logic             frame_tick;

    always #5 clock = ~clock;

    led_matrix_column_scanner #(
        .COLUMNS(C), .ROWS(R), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock), .reset(reset), .scan_enable(scan_enable),
        .column_images(column_images), .tank_level_status(tank_level_status),
        .columns_n(columns_n), .rows(rows), .frame_tick(frame_tick)
    );

    int n_checks = 0, n_fail = 0;

    // Reference model: time since scan start, frame snapshot, run of low-level frames.
    bit           m_active = 1'b0;
    int           m_t = 0;
    int           m_low_run = 0;
    logic [R-1:0] m_img [C];
    logic [C-1:0] e_cn;
    logic [R-1:0] e_rows;
    logic         e_tick;

    typedef struct {
        logic         rst;
        logic         en;
        logic [C-1:0] cn;
        logic [R-1:0] rws;
        logic         tick;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lit();
`ifdef LED_MATRIX_LOW_LEVEL_BLINK_EN
        return ((m_low_run / BF) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_load();
        for (int c = 0; c < C; c++) m_img[c] = column_images[c*R +: R];
    endtask

    task automatic model_edge();
        if (reset || !scan_enable) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            m_active  = 1'b1;
            m_t       = 0;
            m_low_run = 0;
            model_load();
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                model_load();
                m_low_run = (tank_level_status == 2'b00) ? m_low_run + 1 : 0;
            end
        end
        e_cn   = '1;
        e_rows = '0;
        e_tick = m_active && m_t > 0 && (m_t % FRAME == 0);
        if (m_active && (m_t % FRAME) % SLOT >= BL) begin
            e_cn[(m_t % FRAME) / SLOT] = 1'b0;
            e_rows = model_lit() ? m_img[(m_t % FRAME) / SLOT] : '0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("columns_n", 32'(columns_n), 32'(e_cn));
        check("rows", 32'(rows), 32'(e_rows));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic step_to(input int target);
        for (int i = 0; i < 200 && m_t != target; i++) step();
        check("step_to_reached", 32'(m_t), 32'(target));
    endtask

    task automatic set_images_inc();
        for (int c = 0; c < C; c++) column_images[c*R +: R] = R'(c + 1);
    endtask

    initial begin
        int ticks;
        logic [63:0] rnd;
        bit lit [7];

        reset = 1'b1; scan_enable = 1'b0; tank_level_status = 2'b00;
        column_images = '0;
        set_images_inc();

        // 1. reset and first two columns, one record per cycle
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b1, 5'h1F, 7'h00, 1'b0};
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 5'h1F, 7'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 5'h1F, 7'h00, 1'b0};
        for (int i = 6; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 5'b11110, 7'h01, 1'b0};
        for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 1'b1, 5'b11101, 7'h02, 1'b0};
        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst;
            scan_enable = tbl[i].en;
            step();
            check("tbl_columns_n", 32'(columns_n), 32'(tbl[i].cn));
            check("tbl_rows", 32'(rows), 32'(tbl[i].rws));
            check("tbl_frame_tick", 32'(frame_tick), 32'(tbl[i].tick));
        end

        // 2. mid-frame image change is held off until the next snapshot
        step_to(14);
        column_images = {C{7'h7F}};
        step_to(26);
        check("old_image_col4", 32'(rows), 32'h05);
        step_to(30);
        check("tick_at_wrap", 32'(frame_tick), 32'h1);
        step_to(32);
        check("new_image_col0", 32'(rows), 32'h7F);

        // 3. drop enable during column 3, then restart from column 0
        step_to(51);
        scan_enable = 1'b0;
        step();
        check("disable_cols_off", 32'(columns_n), 32'h1F);
        check("disable_rows_off", 32'(rows), 32'h0);
        scan_enable = 1'b1;
        step();
        step();
        check("reenable_blank", 32'(columns_n), 32'h1F);
        step();
        check("reenable_col0", 32'(columns_n), 32'b11110);

        // 4. reset during column 2 of a frame
        step_to(14);
        reset = 1'b1;
        step();
        check("reset_cols", 32'(columns_n), 32'h1F);
        check("reset_rows", 32'(rows), 32'h0);
        reset = 1'b0; scan_enable = 1'b0;
        step();
        step();
        scan_enable = 1'b1;
        step();
        step();
        check("post_reset_blank", 32'(columns_n), 32'h1F);
        step();
        check("post_reset_col0", 32'(columns_n), 32'b11110);

        // 5. three frames of random images: single column low, one tick per frame
        scan_enable = 1'b0;
        step();
        scan_enable = 1'b1;
        ticks = 0;
        for (int i = 0; i < 3 * FRAME + 1; i++) begin
            rnd = {$urandom, $urandom};
            column_images = rnd[C*R-1:0];
            step();
            check("one_col_low", 32'($countones(~columns_n) <= 1), 32'h1);
            if (frame_tick) ticks++;
        end
        check("tick_count_3_frames", 32'(ticks), 32'd3);

        // random enable drops and level codes against the model
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom};
            column_images = rnd[C*R-1:0];
            if ($urandom_range(0, 40) == 0) tank_level_status = 2'($urandom_range(0, 3));
            scan_enable = ($urandom_range(0, 150) != 0);
            step();
        end

        // 6. low-level blink pattern over seven frames, level raised in frame 6
`ifdef LED_MATRIX_LOW_LEVEL_BLINK_EN
        lit = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        lit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        scan_enable = 1'b0; tank_level_status = 2'b00;
        column_images = {C{7'h7F}};
        step();
        scan_enable = 1'b1;
        for (int f = 0; f < 7; f++) begin
            for (int k = 0; k < FRAME; k++) begin
                if (f == 5 && k == 10) tank_level_status = 2'b11;
                step();
                if (k == BL) check($sformatf("blink_frame%0d", f + 1), 32'(rows),
                                   lit[f] ? 32'h7F : 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_column_scanner.md
Name: led_matrix_column_scanner

Overview:
- Time-multiplexes the water tank level image onto the physical LED matrix, one column at a time.
- Inputs are the 7-bit row patterns from the per-column water tank level decoders, packed into one bus.
- Drives one column per scan slot, with a blanking gap between slots to prevent ghosting.
- Snapshots the image once per frame so a frame never shows a mix of old and new levels.

Parameters:
COLUMNS, 5, number of matrix columns scanned
ROWS, 7, rows per column
DWELL_CYCLES, 1000, clock cycles a column is driven (>=1)
BLANK_CYCLES, 16, clock cycles all columns are off before each column (>=1)
BLINK_FRAMES, 32, frames per blink half-period (used only with the optional feature)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
scan_enable  input  1  1 = scanning runs; 0 = display off
column_images  input  COLUMNS*ROWS  decoder outputs; column c at bits [c*ROWS +: ROWS], bit r = row r, 1 = LED lit
tank_level_status  input  2  current tank level code; 2'b00 = lowest level
columns_n  output  COLUMNS  column drivers, active-low, at most one low at a time
rows  output  ROWS  row drivers, active-high
frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- All outputs are driven from registers only. There is no combinational path from any input to any output.
- Reset values: state=OFF, column index col=0, cycle counter cnt=0, snapshot=0, columns_n all 1, rows=0, frame_tick=0.
- Counter widths: cnt is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits; col is $clog2(COLUMNS) bits, minimum 1.
- FSM states: OFF, BLANK, DRIVE.
- OFF:
  - Outputs off: columns_n all 1, rows=0.
  - If scan_enable=1: next state BLANK, col=0, cnt=0, snapshot<=column_images.
- BLANK:
  - Outputs off.
  - cnt counts 0..BLANK_CYCLES-1.
  - At cnt==BLANK_CYCLES-1: next state DRIVE, cnt=0.
- DRIVE:
  - columns_n[col]=0, all other bits 1.
  - rows = snapshot[col*ROWS +: ROWS].
  - cnt counts 0..DWELL_CYCLES-1.
  - At cnt==DWELL_CYCLES-1: next state BLANK, cnt=0.
    - If col<COLUMNS-1: col<=col+1.
    - Else (wrap): col<=0, snapshot<=column_images, frame_tick<=1 for exactly the following cycle.
- Frame period is COLUMNS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- The first frame after leaving OFF does not raise frame_tick.
- Image and level changes in mid-frame have no effect until the next snapshot.
- scan_enable=0 in any state: next state OFF and outputs off on the next cycle; frame_tick=0. The partial frame is abandoned.
- Re-enable: the scan always restarts at column 0 with a fresh snapshot and a full BLANK period.
- reset in mid-scan: takes priority over everything; the next cycle shows reset values.

Optional Feature:
- Macro: LED_MATRIX_LOW_LEVEL_BLINK_EN.
- Enabled:
  - tank_level_status is captured together with the snapshot (snap_level).
  - A frame counter and a blink_phase bit are kept; blink_phase=1 at reset.
  - While snap_level==2'b00: the counter increments on each frame_tick; at BLINK_FRAMES-1 it clears and blink_phase toggles.
  - When blink_phase=0: rows are forced to 0 during DRIVE, while columns keep scanning.
  - When snap_level!=2'b00: the counter clears and blink_phase=1.
  - OFF or reset clears the counter and sets blink_phase=1.
- Disabled: tank_level_status is ignored and rows always follow the snapshot.

Test Plan:
Bench parameters: COLUMNS=5, ROWS=7, DWELL_CYCLES=4, BLANK_CYCLES=2, BLINK_FRAMES=2.
1. Reset for 3 cycles, then scan_enable=1 with column c image = c+1 -> cycles 1-2 all off; cycles 3-6 columns_n=5'b11110, rows=7'h01. Column 1 follows after 2 blank cycles with columns_n=5'b11101, rows=7'h02. Frame = 30 cycles.
2. Change column_images to 7'h7F for all columns during column 2 of frame 1 -> columns 2-4 still show the old values; frame_tick pulses once at cycle 31; all columns show 7'h7F in frame 2.
3. Drop scan_enable during DRIVE of column 3 -> next cycle columns_n=5'h1F, rows=0. Re-enable -> 2 blank cycles, then column 0 driven.
4. Assert reset during DRIVE of column 2 -> next cycle all reset values, state OFF. Scan resumes at column 0 only after scan_enable is seen in OFF.
5. Over 3 full frames: no cycle has more than one columns_n bit low; columns are never low during BLANK; frame_tick is high for exactly 1 cycle per 30.
6. With LED_MATRIX_LOW_LEVEL_BLINK_EN defined and tank_level_status=2'b00 -> frames 1-2 lit, frames 3-4 rows=0, frames 5-6 lit. Set level to 2'b11 -> lit from the next snapshot. Without the macro, every frame is lit.
